// File: rtl/iob_cache_line_fill.sv
// -----------------------------------------------------------------------------
// iob_cache_line_fill
//
// Line-fill controller placed directly in front of the cache data register
// file. On a read miss it fetches one complete cache line from the back-end
// memory, one word per transaction. Words are fetched critical-word-first:
// the word that missed is requested first, then the fetch wraps around
// within the line until every word has been fetched.
//
// Each returned word goes straight into the register file through its
// address / write-data / column-enable port in the same cycle the back end
// acknowledges it. The first word is also forwarded to the requester on
// crit_valid/crit_data. When the last word lands, the controller spends one
// cycle setting the line's valid bit and pulsing fill_done.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset
//   fill_req    start a fill; only sampled while fill_busy = 0
//   fill_addr   byte address of the missed word
//   fill_busy   controller is not idle
//   fill_done   one-cycle pulse, line completely written
//   crit_valid  one-cycle pulse, first (missed) word returned
//   crit_data   missed word, valid with crit_valid
//   mem_valid   back-end request valid
//   mem_addr    back-end word-aligned byte address
//   mem_rdata   back-end read data
//   mem_ready   back-end acknowledge; mem_rdata valid this cycle
//   rf_addr     register-file word address {index, word}
//   rf_wdata    register-file write data
//   rf_en       register-file byte-column write enables
//   v_addr      valid-bit line index
//   v_we        valid-bit set strobe
// -----------------------------------------------------------------------------
module iob_cache_line_fill #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WORD_OFF_W = 2,
  parameter int NLINE_W    = 7
) (
  input  logic                          clk,
  input  logic                          rst,

  // Front end (miss request)
  input  logic                          fill_req,
  input  logic [ADDR_W-1:0]             fill_addr,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic                          crit_valid,
  output logic [DATA_W-1:0]             crit_data,

  // Back-end memory
  output logic                          mem_valid,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ready,

  // Data register file write port
  output logic [NLINE_W+WORD_OFF_W-1:0] rf_addr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic [DATA_W/8-1:0]           rf_en,

  // Valid-bit array set port
  output logic [NLINE_W-1:0]            v_addr,
  output logic                          v_we
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int NUM_COL = DATA_W / 8;
  localparam int BYTE_W  = $clog2(DATA_W / 8);
  localparam int TAG_W   = ADDR_W - BYTE_W - WORD_OFF_W - NLINE_W;

  // ---------------------------------------------------------------------------
  // Address split of the missed address
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0]      req_tag;
  logic [NLINE_W-1:0]    req_index;
  logic [WORD_OFF_W-1:0] req_word;

  assign req_word  = fill_addr[BYTE_W +: WORD_OFF_W];
  assign req_index = fill_addr[BYTE_W+WORD_OFF_W +: NLINE_W];
  assign req_tag   = fill_addr[ADDR_W-1 -: TAG_W];

  // The byte offset is irrelevant: the whole line is always fetched and
  // back-end addresses are word aligned.
  logic unused_byte_off;
  assign unused_byte_off = ^fill_addr[BYTE_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Fill context, captured when a request is accepted.
  logic [TAG_W-1:0]      tag_q;
  logic [NLINE_W-1:0]    index_q;
  logic [WORD_OFF_W-1:0] cur_word_q;  // word currently being fetched
  logic [WORD_OFF_W-1:0] remain_q;    // words still to fetch after cur_word_q

  logic accept;      // new fill taken this cycle
  logic beat;        // back end returns a word this cycle
  logic first_beat;  // the returning word is the critical (missed) one

  assign accept     = (state_q == S_IDLE) && fill_req;
  assign beat       = (state_q == S_REQ) && mem_ready;
  // remain starts at NWORDS-1, which is all ones, and only drops after a beat.
  assign first_beat = (remain_q == '1);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (fill_req)                  state_d = S_REQ;
      S_REQ:  if (mem_ready && remain_q == '0) state_d = S_DONE;
      S_DONE:                                state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // Fill context registers.
  // NOTE: these are deliberately not reset. They are only observed in REQ and
  // DONE, and the only way into REQ is through IDLE, which loads them first.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q      <= req_tag;
      index_q    <= req_index;
      cur_word_q <= req_word;
      remain_q   <= '1;
    end else if (beat) begin
      // Natural wrap of the WORD_OFF_W-bit counter gives the mod-NWORDS step.
      cur_word_q <= cur_word_q + WORD_OFF_W'(1);
      remain_q   <= remain_q - WORD_OFF_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  //
  // All outputs are decoded from the current state. They are additionally
  // forced to zero while rst is high, so a reset raised mid-fill stops any
  // register-file write in that same cycle and the outputs read zero during
  // the whole reset window, even before the state register has been reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    fill_busy  = 1'b0;
    fill_done  = 1'b0;
    crit_valid = 1'b0;
    crit_data  = '0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    rf_addr    = '0;
    rf_wdata   = '0;
    rf_en      = '0;
    v_addr     = '0;
    v_we       = 1'b0;

    if (!rst) begin
      fill_busy = (state_q != S_IDLE);

      case (state_q)
        S_REQ: begin
          // Request stays up (and stable) until the back end acknowledges;
          // consecutive words are requested back to back.
          mem_valid = 1'b1;
          mem_addr  = {tag_q, index_q, cur_word_q, {BYTE_W{1'b0}}};
          if (mem_ready) begin
            // Returned word is passed straight through to the register file.
            rf_en    = {NUM_COL{1'b1}};
            rf_wdata = mem_rdata;
            rf_addr  = {index_q, cur_word_q};
            if (first_beat) begin
              crit_valid = 1'b1;
              crit_data  = mem_rdata;
            end
          end
        end

        S_DONE: begin
          fill_done = 1'b1;
          v_we      = 1'b1;
          v_addr    = index_q;
        end

        default: ;
      endcase
    end
  end

endmodule
